// File: rtl/mpu_store_sequencer.sv
`default_nettype none
// mpu_store_sequencer: drains one mpu_register_file matrix register to memory
// as a row-major element stream through a 2-entry credit-managed output FIFO.
module mpu_store_sequencer #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_SIZE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_in,
  input  logic [MATRIX_REG_SIZE-1:0] start_addr_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       reg_store_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out,
  output logic [MBITS:0]             reg_i_store_loc_out,
  output logic [NBITS:0]             reg_j_store_loc_out,
  input  logic [MBITS:0]             reg_m_store_size_in,
  input  logic [NBITS:0]             reg_n_store_size_in,
  input  logic [FP-1:0]              reg_store_element_in,
  output logic                       mem_valid_out,
  input  logic                       mem_ready_in,
  output logic [FP-1:0]              mem_element_out,
  output logic [MBITS:0]             mem_i_out,
  output logic [NBITS:0]             mem_j_out,
  output logic                       mem_last_out
);

  localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);
  localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
  localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [MBITS:0] m_q, m_d;
  logic [NBITS:0] n_q, n_d;

  // Read-return pipeline: data for a strobe seen last cycle is on the inputs now.
  logic           ret_valid_q;
  logic [MBITS:0] ret_i_q;
  logic [NBITS:0] ret_j_q;

  logic [1:0]     fifo_count_q;
  logic [FP-1:0]  s1_elem_q;
  logic [MBITS:0] s1_i_q;
  logic [NBITS:0] s1_j_q;
  logic           s1_last_q;

  logic                       busy_d, done_d, en_d;
  logic [MATRIX_REG_SIZE-1:0] addr_d;
  logic [MBITS:0]             i_d;
  logic [NBITS:0]             j_d;
  logic                       push, push_last, pop;

  logic [MBITS:0] m_sat;
  logic [NBITS:0] n_sat;
  logic           ret_is_last;
  logic           wrap;
  logic [MBITS:0] nxt_i;
  logic [NBITS:0] nxt_j;
  logic           nxt_is_last;
  logic [2:0]     occ;
  logic           credit_ok;

  assign m_sat = (reg_m_store_size_in > M_MAX) ? M_MAX : reg_m_store_size_in;
  assign n_sat = (reg_n_store_size_in > N_MAX) ? N_MAX : reg_n_store_size_in;

  assign pop         = mem_valid_out & mem_ready_in;
  assign ret_is_last = (ret_i_q == m_q - M_ONE) && (ret_j_q == n_q - N_ONE);

  assign wrap        = (reg_j_store_loc_out == n_q - N_ONE);
  assign nxt_j       = wrap ? '0 : reg_j_store_loc_out + N_ONE;
  assign nxt_i       = wrap ? reg_i_store_loc_out + M_ONE : reg_i_store_loc_out;
  assign nxt_is_last = (nxt_i == m_q - M_ONE) && (nxt_j == n_q - N_ONE);

  // Everything that will eventually occupy the FIFO must fit in its 2 entries.
  assign occ       = {1'b0, fifo_count_q} + {2'b00, reg_store_en_out} + {2'b00, ret_valid_q};
  assign credit_ok = (occ - {2'b00, pop}) < 3'd2;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_out;
    done_d    = 1'b0;
    en_d      = 1'b0;
    addr_d    = reg_store_addr_out;
    i_d       = reg_i_store_loc_out;
    j_d       = reg_j_store_loc_out;
    m_d       = m_q;
    n_d       = n_q;
    push      = 1'b0;
    push_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = PROBE;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          addr_d  = start_addr_in;
          i_d     = '0;
          j_d     = '0;
        end
      end
      PROBE: begin
        if (ret_valid_q) begin
          m_d = m_sat;
          n_d = n_sat;
          if (m_sat == '0 || n_sat == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            push      = 1'b1;
            push_last = (m_sat == M_ONE) && (n_sat == N_ONE);
            // A 1x1 matrix has already had its only read issued.
            state_d   = push_last ? DRAIN : STREAM;
          end
        end
      end
      STREAM: begin
        push      = ret_valid_q;
        push_last = ret_is_last;
        if (credit_ok) begin
          en_d = 1'b1;
          i_d  = nxt_i;
          j_d  = nxt_j;
          if (nxt_is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        push      = ret_valid_q;
        push_last = ret_is_last;
        if (pop && mem_last_out) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      busy_out            <= 1'b0;
      done_out            <= 1'b0;
      reg_store_en_out    <= 1'b0;
      reg_store_addr_out  <= '0;
      reg_i_store_loc_out <= '0;
      reg_j_store_loc_out <= '0;
      m_q                 <= '0;
      n_q                 <= '0;
      ret_valid_q         <= 1'b0;
      ret_i_q             <= '0;
      ret_j_q             <= '0;
    end else begin
      state_q             <= state_d;
      busy_out            <= busy_d;
      done_out            <= done_d;
      reg_store_en_out    <= en_d;
      reg_store_addr_out  <= addr_d;
      reg_i_store_loc_out <= i_d;
      reg_j_store_loc_out <= j_d;
      m_q                 <= m_d;
      n_q                 <= n_d;
      ret_valid_q         <= reg_store_en_out;
      ret_i_q             <= reg_i_store_loc_out;
      ret_j_q             <= reg_j_store_loc_out;
    end
  end

  // The head entry lives directly in the mem_* output registers; s1 is the second slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count_q    <= 2'd0;
      mem_valid_out   <= 1'b0;
      mem_element_out <= '0;
      mem_i_out       <= '0;
      mem_j_out       <= '0;
      mem_last_out    <= 1'b0;
      s1_elem_q       <= '0;
      s1_i_q          <= '0;
      s1_j_q          <= '0;
      s1_last_q       <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (fifo_count_q == 2'd0) begin
            mem_element_out <= reg_store_element_in;
            mem_i_out       <= ret_i_q;
            mem_j_out       <= ret_j_q;
            mem_last_out    <= push_last;
          end else begin
            s1_elem_q <= reg_store_element_in;
            s1_i_q    <= ret_i_q;
            s1_j_q    <= ret_j_q;
            s1_last_q <= push_last;
          end
          fifo_count_q  <= fifo_count_q + 2'd1;
          mem_valid_out <= 1'b1;
        end
        2'b01: begin
          if (fifo_count_q == 2'd2) begin
            mem_element_out <= s1_elem_q;
            mem_i_out       <= s1_i_q;
            mem_j_out       <= s1_j_q;
            mem_last_out    <= s1_last_q;
          end
          fifo_count_q  <= fifo_count_q - 2'd1;
          mem_valid_out <= (fifo_count_q == 2'd2);
        end
        2'b11: begin
          if (fifo_count_q == 2'd1) begin
            mem_element_out <= reg_store_element_in;
            mem_i_out       <= ret_i_q;
            mem_j_out       <= ret_j_q;
            mem_last_out    <= push_last;
          end else begin
            mem_element_out <= s1_elem_q;
            mem_i_out       <= s1_i_q;
            mem_j_out       <= s1_j_q;
            mem_last_out    <= s1_last_q;
            s1_elem_q       <= reg_store_element_in;
            s1_i_q          <= ret_i_q;
            s1_j_q          <= ret_j_q;
            s1_last_q       <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpu_store_sequencer.sv
`default_nettype none
// Randomized bench for mpu_store_sequencer with a register-file responder and a
// row-major expected-beat model derived from the saturated matrix size.
module tb_mpu_store_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [1:0]  start_addr_in;
  logic        busy_out, done_out, reg_store_en_out;
  logic [1:0]  reg_store_addr_out;
  logic [2:0]  reg_i_store_loc_out, reg_j_store_loc_out;
  logic [2:0]  reg_m_store_size_in, reg_n_store_size_in;
  logic [31:0] reg_store_element_in;
  logic        mem_valid_out, mem_ready_in;
  logic [31:0] mem_element_out;
  logic [2:0]  mem_i_out, mem_j_out;
  logic        mem_last_out;

  mpu_store_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .start_in(start_in), .start_addr_in(start_addr_in),
    .busy_out(busy_out), .done_out(done_out),
    .reg_store_en_out(reg_store_en_out), .reg_store_addr_out(reg_store_addr_out),
    .reg_i_store_loc_out(reg_i_store_loc_out), .reg_j_store_loc_out(reg_j_store_loc_out),
    .reg_m_store_size_in(reg_m_store_size_in), .reg_n_store_size_in(reg_n_store_size_in),
    .reg_store_element_in(reg_store_element_in),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
    .mem_element_out(mem_element_out), .mem_i_out(mem_i_out), .mem_j_out(mem_j_out),
    .mem_last_out(mem_last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rf_mat [4][4][4];
  logic [2:0]  rf_m [4];
  logic [2:0]  rf_n [4];

  // Register file: registered read port, garbage whenever no read was strobed.
  always @(posedge clk) begin
    if (reg_store_en_out) begin
      if (reg_i_store_loc_out < 3'd4 && reg_j_store_loc_out < 3'd4)
        reg_store_element_in <= rf_mat[reg_store_addr_out][int'(reg_i_store_loc_out)][int'(reg_j_store_loc_out)];
      else
        reg_store_element_in <= 32'hDEAD_BEEF;
      reg_m_store_size_in <= rf_m[reg_store_addr_out];
      reg_n_store_size_in <= rf_n[reg_store_addr_out];
    end else begin
      reg_store_element_in <= $urandom;
      reg_m_store_size_in  <= 3'($urandom);
      reg_n_store_size_in  <= 3'($urandom);
    end
  end

  logic [31:0] exp_elem[$];
  logic [2:0]  exp_i[$], exp_j[$];
  logic        exp_last[$];
  logic [31:0] g_elem[$];
  logic [2:0]  g_i[$], g_j[$];
  logic        g_last[$];
  int done_cnt, first_valid_k, done_k, last_k, stall_viol, max_out, issued;
  bit timed_out, busy_at_done;

  task automatic fill_matrix(input int a, input int m, input int n);
    rf_m[a] = 3'(m);
    rf_n[a] = 3'(n);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        rf_mat[a][i][j] = $urandom;
  endtask

  task automatic build_expected(input int a);
    int ms, ns;
    ms = (rf_m[a] > 3'd4) ? 4 : int'(rf_m[a]);
    ns = (rf_n[a] > 3'd4) ? 4 : int'(rf_n[a]);
    exp_elem.delete(); exp_i.delete(); exp_j.delete(); exp_last.delete();
    for (int i = 0; i < ms; i++)
      for (int j = 0; j < ns; j++) begin
        exp_elem.push_back(rf_mat[a][i][j]);
        exp_i.push_back(3'(i));
        exp_j.push_back(3'(j));
        exp_last.push_back(i == ms - 1 && j == ns - 1);
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_in = 1'b0; mem_ready_in = 1'b0; start_addr_in = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Launches one store and records what the memory side observes; k counts
  // cycles after the start edge (k=1 is the cycle right after it).
  task automatic run_store(input int a, input int mode, input bit hold, input int abort_beat, input int budget);
    int k, accepted;
    bit stalled;
    logic [40:0] head;
    g_elem.delete(); g_i.delete(); g_j.delete(); g_last.delete();
    done_cnt = 0; first_valid_k = 0; done_k = 0; last_k = 0; stall_viol = 0;
    max_out = 0; issued = 0; timed_out = 0; busy_at_done = 1'b1;
    accepted = 0; stalled = 0; head = '0; k = 0;
    start_in = 1'b1; start_addr_in = 2'(a);
    while (1) begin
      @(negedge clk);
      k++;
      if (!hold) start_in = 1'b0;
      case (mode)
        0: mem_ready_in = 1'b1;
        1: mem_ready_in = k[0];
        2: mem_ready_in = !(k >= 4 && k <= 8);
        default: mem_ready_in = 1'($urandom_range(0, 1));
      endcase
      if (reg_store_en_out) issued++;
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (stalled && !(mem_valid_out && {mem_element_out, mem_i_out, mem_j_out, mem_last_out} == head))
        stall_viol++;
      stalled = mem_valid_out && !mem_ready_in;
      head = {mem_element_out, mem_i_out, mem_j_out, mem_last_out};
      if (mem_valid_out && first_valid_k == 0) first_valid_k = k;
      if (mem_valid_out && mem_ready_in) begin
        g_elem.push_back(mem_element_out); g_i.push_back(mem_i_out);
        g_j.push_back(mem_j_out); g_last.push_back(mem_last_out);
        accepted++;
        last_k = k;
      end
      if (done_out) begin
        done_cnt++;
        if (done_k == 0) begin done_k = k; busy_at_done = busy_out; end
      end
      if (abort_beat > 0 && accepted == abort_beat) begin rst_n = 1'b0; break; end
      if (done_k != 0 && (hold || k >= done_k + 3)) break;
      if (k >= budget) begin timed_out = 1'b1; break; end
    end
    mem_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy_out, done_out, reg_store_en_out, reg_store_addr_out, reg_i_store_loc_out, reg_j_store_loc_out,
         mem_valid_out, mem_element_out, mem_i_out, mem_j_out, mem_last_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b done=%b en=%b valid=%b elem=%h exp all zero",
               busy_out, done_out, reg_store_en_out, mem_valid_out, mem_element_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy_out !== 1'b0 || reg_store_en_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle got busy=%b en=%b exp 0/0", busy_out, reg_store_en_out);
    end
  endtask

  task automatic test_2x3();
    fill_matrix(1, 2, 3);
    build_expected(1);
    for (int mode = 0; mode < 3; mode++) begin
      run_store(1, mode, 1'b0, 0, 200);
      vectors++;
      if (timed_out || g_elem.size() != 6) begin
        miscompares++;
        $display("FAIL 2x3_m%0d beat_count got=%0d exp=6 timeout=%0b", mode, g_elem.size(), timed_out);
      end
      for (int b = 0; b < 6 && b < g_elem.size(); b++) begin
        vectors++;
        if ({g_elem[b], g_i[b], g_j[b], g_last[b]} !== {exp_elem[b], exp_i[b], exp_j[b], exp_last[b]}) begin
          miscompares++;
          $display("FAIL 2x3_m%0d beat%0d got=%h(%0d,%0d)l%0b exp=%h(%0d,%0d)l%0b", mode, b,
                   g_elem[b], g_i[b], g_j[b], g_last[b], exp_elem[b], exp_i[b], exp_j[b], exp_last[b]);
        end
      end
      vectors++;
      if (done_cnt != 1 || done_k != last_k + 1 || busy_at_done !== 1'b0) begin
        miscompares++;
        $display("FAIL 2x3_m%0d done got cnt=%0d at=%0d busy=%b exp cnt=1 at=%0d busy=0",
                 mode, done_cnt, done_k, busy_at_done, last_k + 1);
      end
      vectors++;
      if (stall_viol != 0 || max_out > 2 || issued != 6) begin
        miscompares++;
        $display("FAIL 2x3_m%0d flow got stall=%0d max_out=%0d reads=%0d exp 0/<=2/6",
                 mode, stall_viol, max_out, issued);
      end
      if (mode == 0) begin
        vectors++;
        if (first_valid_k != 3) begin
          miscompares++;
          $display("FAIL 2x3_first_valid got=%0d exp=3", first_valid_k);
        end
      end
    end
  endtask

  task automatic test_empty();
    fill_matrix(0, 0, 3);
    run_store(0, 0, 1'b0, 0, 50);
    vectors++;
    if (timed_out || first_valid_k != 0 || done_cnt != 1 || done_k != 3 || busy_at_done !== 1'b0 || issued != 1) begin
      miscompares++;
      $display("FAIL empty got valid_at=%0d done=%0d@%0d busy=%b reads=%0d exp 0/1@3/0/1",
               first_valid_k, done_cnt, done_k, busy_at_done, issued);
    end
  endtask

  task automatic test_1x1();
    fill_matrix(2, 1, 1);
    rf_mat[2][0][0] = 32'h3F80_0000;
    run_store(2, 0, 1'b0, 0, 50);
    vectors++;
    if (timed_out || g_elem.size() != 1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL 1x1_count got beats=%0d done=%0d exp 1/1", g_elem.size(), done_cnt);
    end else begin
      vectors++;
      if ({g_elem[0], g_i[0], g_j[0], g_last[0]} !== {32'h3F80_0000, 3'd0, 3'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL 1x1_beat got=%h(%0d,%0d)l%0b exp=3f800000(0,0)l1", g_elem[0], g_i[0], g_j[0], g_last[0]);
      end
    end
  endtask

  task automatic test_hold_start();
    fill_matrix(3, 4, 4);
    build_expected(3);
    run_store(3, 0, 1'b1, 0, 200);
    vectors++;
    if (timed_out || g_elem.size() != 16 || done_cnt != 1 || issued != 16) begin
      miscompares++;
      $display("FAIL hold_count got beats=%0d done=%0d reads=%0d exp 16/1/16", g_elem.size(), done_cnt, issued);
    end
    for (int b = 0; b < 16 && b < g_elem.size(); b++) begin
      vectors++;
      if ({g_elem[b], g_i[b], g_j[b], g_last[b]} !== {exp_elem[b], exp_i[b], exp_j[b], exp_last[b]}) begin
        miscompares++;
        $display("FAIL hold_beat%0d got=%h(%0d,%0d)l%0b exp=%h(%0d,%0d)l%0b", b,
                 g_elem[b], g_i[b], g_j[b], g_last[b], exp_elem[b], exp_i[b], exp_j[b], exp_last[b]);
      end
    end
    @(negedge clk);
    vectors++;
    if (busy_out !== 1'b1 || reg_store_en_out !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_restart got busy=%b en=%b exp 1/1", busy_out, reg_store_en_out);
    end
    start_in = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid();
    fill_matrix(1, 4, 4);
    build_expected(1);
    run_store(1, 0, 1'b0, 5, 200);
    #1;
    vectors++;
    if (timed_out || done_cnt != 0 ||
        {busy_out, done_out, reg_store_en_out, reg_store_addr_out, reg_i_store_loc_out, reg_j_store_loc_out,
         mem_valid_out, mem_element_out, mem_i_out, mem_j_out, mem_last_out} !== '0) begin
      miscompares++;
      $display("FAIL midreset got busy=%b en=%b valid=%b elem=%h done=%0d exp all zero, no done",
               busy_out, reg_store_en_out, mem_valid_out, mem_element_out, done_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_store(1, 0, 1'b0, 0, 200);
    vectors++;
    if (timed_out || g_elem.size() != 16 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL midreset_rerun got beats=%0d done=%0d exp 16/1", g_elem.size(), done_cnt);
    end
    for (int b = 0; b < 16 && b < g_elem.size(); b++) begin
      vectors++;
      if ({g_elem[b], g_i[b], g_j[b], g_last[b]} !== {exp_elem[b], exp_i[b], exp_j[b], exp_last[b]}) begin
        miscompares++;
        $display("FAIL midreset_beat%0d got=%h(%0d,%0d)l%0b exp=%h(%0d,%0d)l%0b", b,
                 g_elem[b], g_i[b], g_j[b], g_last[b], exp_elem[b], exp_i[b], exp_j[b], exp_last[b]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int a;
      a = $urandom_range(0, 3);
      fill_matrix(a, (t == 0) ? 7 : $urandom_range(0, 7), (t == 0) ? 5 : $urandom_range(0, 7));
      build_expected(a);
      run_store(a, 3, 1'b0, 0, 600);
      vectors++;
      if (timed_out || g_elem.size() != exp_elem.size() || done_cnt != 1 || stall_viol != 0 || max_out > 2) begin
        miscompares++;
        $display("FAIL rand%0d got beats=%0d done=%0d stall=%0d max_out=%0d exp %0d/1/0/<=2 (m=%0d n=%0d)",
                 t, g_elem.size(), done_cnt, stall_viol, max_out, exp_elem.size(), rf_m[a], rf_n[a]);
      end
      for (int b = 0; b < exp_elem.size() && b < g_elem.size(); b++) begin
        vectors++;
        if ({g_elem[b], g_i[b], g_j[b], g_last[b]} !== {exp_elem[b], exp_i[b], exp_j[b], exp_last[b]}) begin
          miscompares++;
          $display("FAIL rand%0d beat%0d got=%h(%0d,%0d)l%0b exp=%h(%0d,%0d)l%0b", t, b,
                   g_elem[b], g_i[b], g_j[b], g_last[b], exp_elem[b], exp_i[b], exp_j[b], exp_last[b]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_in = 1'b0; start_addr_in = 2'd0; mem_ready_in = 1'b0;
    for (int a = 0; a < 4; a++) fill_matrix(a, 0, 0);
    test_reset();
    test_2x3();
    test_empty();
    test_1x1();
    test_hold_start();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
